// File: rtl/sr595_pkg.sv
// Shared constants for the sr595 serial-in/parallel-out shift register.
package sr595_pkg;

    localparam int SR595_WIDTH_DEF       = 8;
    localparam int SR595_SYNC_STAGES_DEF = 2;
    // Strobe and clear flops idle high so a pin held high through reset yields no edge
    localparam logic STROBE_RST_VAL      = 1'b1;

endpackage

// File: rtl/sr595_sync_edge.sv
// Optional synchronizer chain plus rising-edge detector for one strobe pin.
// STAGES=0 leaves a single sampling flop; level and rise then lag the pin by one clock.
module sync_edge #(
    parameter int   STAGES    = 0,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int N = (STAGES == 0) ? 1 : STAGES;

    logic [N-1:0] chain_r;
    logic [N:0]   taps_s;
    logic         rise_r;

    // The raw pin sits below the chain, so taps_s[N-1] is one sample newer than taps_s[N]
    assign taps_s = {chain_r, pin};

    // Sample chain and registered edge pulse; the pulse is computed one stage early so
    // the update edge stays at t0+STAGES (or t0+1 with no synchronizer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {N{RESET_VAL}};
            rise_r  <= 1'b0;
        end else begin
            chain_r <= taps_s[N-1:0];
            rise_r  <= taps_s[N-1] & ~taps_s[N];
        end
    end

    assign level = taps_s[N];
    assign rise  = rise_r;

endmodule

// File: rtl/sr595.sv
// 74x595-style shift register with storage latch and cascade output.
// Define SR595_SYNC_EN to pass SRCLK, RCLK, SRCLR_N and SER through SYNC_STAGES flops.
module sr595
    import sr595_pkg::*;
#(
    parameter int WIDTH       = SR595_WIDTH_DEF,
    parameter int SYNC_STAGES = SR595_SYNC_STAGES_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SER,
    input  logic             SRCLK,
    input  logic             RCLK,
    input  logic             SRCLR_N,
    input  logic             OE_N,
    output logic [WIDTH-1:0] Q,
    output logic             QH_PRIME
);

`ifdef SR595_SYNC_EN
    localparam bit SYNC_EN_C = 1'b1;
`else
    localparam bit SYNC_EN_C = 1'b0;
`endif
    localparam int STAGES_EFF = SYNC_EN_C ? SYNC_STAGES : 0;
    localparam int SER_N      = (STAGES_EFF == 0) ? 1 : STAGES_EFF;

    logic             shift_pulse_s;
    logic             latch_pulse_s;
    logic             srclr_level_s;
    logic             srclk_level_unused_s;
    logic             rclk_level_unused_s;
    logic             srclr_rise_unused_s;
    logic             clr_s;
    logic             ser_d_s;
    logic [SER_N-1:0] ser_pipe_r;
    logic [SER_N:0]   ser_taps_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] store_r;

    sync_edge #(.STAGES(STAGES_EFF), .RESET_VAL(STROBE_RST_VAL)) u_srclk (
        .clk(CLK), .rst(RST), .pin(SRCLK),
        .level(srclk_level_unused_s), .rise(shift_pulse_s)
    );

    sync_edge #(.STAGES(STAGES_EFF), .RESET_VAL(STROBE_RST_VAL)) u_rclk (
        .clk(CLK), .rst(RST), .pin(RCLK),
        .level(rclk_level_unused_s), .rise(latch_pulse_s)
    );

    sync_edge #(.STAGES(STAGES_EFF), .RESET_VAL(STROBE_RST_VAL)) u_srclr (
        .clk(CLK), .rst(RST), .pin(SRCLR_N),
        .level(srclr_level_s), .rise(srclr_rise_unused_s)
    );

    assign clr_s      = ~srclr_level_s;
    assign ser_taps_s = {ser_pipe_r, SER};
    assign ser_d_s    = ser_taps_s[SER_N];

    // SER delay line, as deep as the strobe path so data stays aligned with its shift pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ser_pipe_r <= {SER_N{1'b0}};
        end else begin
            ser_pipe_r <= ser_taps_s[SER_N-1:0];
        end
    end

    // Shift and storage registers; latch always captures the pre-clear, pre-shift value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_r <= {WIDTH{1'b0}};
            store_r <= {WIDTH{1'b0}};
        end else begin
            if (clr_s) begin
                shift_r <= {WIDTH{1'b0}};
            end else if (shift_pulse_s) begin
                shift_r <= {shift_r[WIDTH-2:0], ser_d_s};
            end else begin
                shift_r <= shift_r;
            end
            if (latch_pulse_s) begin
                store_r <= shift_r;
            end else begin
                store_r <= store_r;
            end
        end
    end

    assign Q        = OE_N ? {WIDTH{1'bz}} : store_r;
    assign QH_PRIME = shift_r[WIDTH-1];

endmodule

// File: tb/tb_sr595.sv
// Self-checking bench for sr595: reset, shifting, latching, cascade, clear, OE and latency.
module tb_sr595;

    localparam int W = 8;
`ifdef SR595_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        string      name;
        logic [7:0] byte_in;
        logic [7:0] exp_q;
        logic       exp_qh;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         SER;
    logic         SRCLK;
    logic         RCLK;
    logic         SRCLR_N;
    logic         OE_N;
    wire  [W-1:0] q_w;
    wire          qh_w;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] shift_m;
    logic [W-1:0] store_m;
    vec_t         vecs[6];

    always #5 CLK = ~CLK;

    sr595 dut (
        .CLK(CLK), .RST(RST), .SER(SER), .SRCLK(SRCLK), .RCLK(RCLK),
        .SRCLR_N(SRCLR_N), .OE_N(OE_N), .Q(q_w), .QH_PRIME(qh_w)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        check({name, "_q"}, q_w, store_m);
        check({name, "_qh"}, {7'd0, qh_w}, {7'd0, shift_m[W-1]});
    endtask

    // One strobe cycle: 4 clocks high, 4 clocks low; reference model updated afterwards
    task automatic strobe(input logic s, input logic r, input logic b);
        @(negedge CLK);
        SER   = b;
        SRCLK = s;
        RCLK  = r;
        repeat (4) @(negedge CLK);
        SRCLK = 1'b0;
        RCLK  = 1'b0;
        repeat (4) @(negedge CLK);
        if (r) store_m = shift_m;
        if (s) shift_m = {shift_m[W-2:0], b};
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) strobe(1'b1, 1'b0, v[i]);
    endtask

    task automatic clear_pulse();
        @(negedge CLK);
        SRCLR_N = 1'b0;
        repeat (4) @(negedge CLK);
        SRCLR_N = 1'b1;
        repeat (4) @(negedge CLK);
        shift_m = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] casc;
        logic [7:0] tied;
        int         k;

        vecs[0] = '{"vec_b2", 8'hB2, 8'hB2, 1'b1};
        vecs[1] = '{"vec_5a", 8'h5A, 8'h5A, 1'b0};
        vecs[2] = '{"vec_01", 8'h01, 8'h01, 1'b0};
        vecs[3] = '{"vec_ff", 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{"vec_80", 8'h80, 8'h80, 1'b1};
        vecs[5] = '{"vec_3c", 8'h3C, 8'h3C, 1'b0};

        // Reset with strobes held high through release
        RST = 1'b1; SER = 1'b1; SRCLK = 1'b1; RCLK = 1'b1; SRCLR_N = 1'b1; OE_N = 1'b0;
        shift_m = '0; store_m = '0;
        repeat (3) @(negedge CLK);
        check("reset_q", q_w, 8'h00);
        check("reset_qh", {7'd0, qh_w}, 8'h00);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        SRCLK = 1'b0; RCLK = 1'b0;
        repeat (4) @(negedge CLK);
        check_state("post_release");
        strobe(1'b0, 1'b1, 1'b0);
        check_state("no_shift_on_release");

        // Shift B2, store must hold until the latch strobe
        shift_byte(8'hB2);
        check("store_hold_q", q_w, 8'h00);
        strobe(1'b0, 1'b1, 1'b0);
        check("latch_b2_q", q_w, 8'hB2);
        check("latch_b2_qh", {7'd0, qh_w}, 8'h01);

        // Cascade: shifting ones pushes the old byte out of QH_PRIME MSB first
        casc = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cascade_%0d", i), {7'd0, qh_w}, {7'd0, casc[7-i]});
            strobe(1'b1, 1'b0, 1'b1);
        end
        check_state("cascade_end");

        // Tied strobes: store lags shift by one bit
        tied = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            strobe(1'b1, 1'b1, tied[i]);
            check_state("tied");
        end
        check("tied_final_q", q_w, 8'h80);

        // Output enable and shift-register clear
        shift_byte(8'h5A);
        strobe(1'b0, 1'b1, 1'b0);
        check("load_5a_q", q_w, 8'h5A);
        OE_N = 1'b1;
        #1;
        tests++;
        if (!((q_w === {W{1'bz}}) || (q_w === {W{1'b0}}))) begin
            fails++;
            $display("FAIL oe_hiz: got %h, want zz", q_w);
        end
        OE_N = 1'b0;
        #1;
        check("oe_restore_q", q_w, 8'h5A);
        clear_pulse();
        check("clear_no_latch_q", q_w, 8'h5A);
        check("clear_qh", {7'd0, qh_w}, 8'h00);
        strobe(1'b0, 1'b1, 1'b0);
        check("clear_latch_q", q_w, 8'h00);

        // Reset mid-byte discards partial shifts
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        shift_m = '0; store_m = '0;
        @(negedge CLK);
        check_state("mid_reset");
        RST = 1'b0;
        shift_byte(8'hC3);
        strobe(1'b0, 1'b1, 1'b0);
        check("post_reset_q", q_w, 8'hC3);

        // Latch latency from pin edge
        shift_byte(8'h0F);
        @(negedge CLK);
        RCLK = 1'b1;
        k = 0;
        do begin
            @(posedge CLK);
            #1;
            k++;
        end while (q_w !== 8'h0F && k < 10);
        check("latch_latency", k - 1, LAT);
        repeat (4) @(negedge CLK);
        RCLK = 1'b0;
        repeat (4) @(negedge CLK);
        store_m = shift_m;

        // Shift latency observed on QH_PRIME
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b1);
        check_state("pre_shift_latency");
        @(negedge CLK);
        SER = 1'b1;
        SRCLK = 1'b1;
        k = 0;
        do begin
            @(posedge CLK);
            #1;
            k++;
        end while (qh_w !== 1'b1 && k < 10);
        check("shift_latency", k - 1, LAT);
        repeat (4) @(negedge CLK);
        SRCLK = 1'b0;
        repeat (4) @(negedge CLK);
        shift_m = {shift_m[W-2:0], 1'b1};

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    strobe(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                2:       strobe(1'b0, 1'b1, 1'b0);
                3:       strobe(1'b1, 1'b1, 1'($urandom_range(0, 1)));
                default: clear_pulse();
            endcase
            check_state($sformatf("rand_%0d", n));
        end

        // Table of full-byte loads
        foreach (vecs[i]) begin
            shift_byte(vecs[i].byte_in);
            check({vecs[i].name, "_hold"}, q_w, store_m);
            strobe(1'b0, 1'b1, 1'b0);
            check({vecs[i].name, "_q"}, q_w, vecs[i].exp_q);
            check({vecs[i].name, "_qh"}, {7'd0, qh_w}, {7'd0, vecs[i].exp_qh});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
